// File: rtl/ysyx_24080006_icache_refill.sv
// Instruction-cache controller: tag lookup on the line store read port, AXI4
// INCR line refill on a miss, single-port line write-back, and a valid/ready
// response carrying the requested 32-bit word back to the fetch stage.
module ysyx_24080006_icache_refill #(
  parameter int IC_N  = 4,
  parameter int IC_M  = 4,
  parameter int TAG_W = 32 - IC_N - IC_M
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fencei,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_addr,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_data,
  output logic                   resp_err,
  output logic [IC_N-1:0]        ic_index,
  input  logic                   ic_rvalid,
  input  logic [TAG_W-1:0]       ic_rtag,
  input  logic [32*(2**(IC_M-2))-1:0] ic_rline,
  output logic                   ic_we,
  output logic [IC_N-1:0]        ic_waddr,
  output logic [TAG_W-1:0]       ic_wtag,
  output logic [32*(2**(IC_M-2))-1:0] ic_wline,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [31:0]            araddr,
  output logic [7:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [31:0]            rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast
);

  localparam int LW     = 2 ** (IC_M - 2);
  localparam int BW     = IC_M - 2;
  localparam int LINE_B = 2 ** IC_M;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_WB,
    S_RESP
  } state_e;

  state_e                 state_q;
  logic [IC_N-1:0]        idx_q;
  logic [TAG_W-1:0]       tag_q;
  logic [BW-1:0]          off_q;
  logic [BW-1:0]          beat_q;
  logic [LW-1:0][31:0]    line_q;
  logic                   err_q;
  logic                   kill_q;
  logic                   req_ready_q;
  logic                   resp_valid_q;
  logic                   resp_err_q;
  logic [31:0]            resp_data_q;
  logic                   arvalid_q;
  logic [31:0]            araddr_q;
  logic                   rready_q;

  logic [LW-1:0][31:0]    rline_w;
  logic [IC_N-1:0]        req_idx;
  logic [TAG_W-1:0]       req_tag;
  logic [BW-1:0]          req_off;
  logic                   hit;
  logic                   beat_last;

  assign rline_w   = ic_rline;
  assign req_idx   = req_addr[IC_M+IC_N-1:IC_M];
  assign req_tag   = req_addr[31:IC_M+IC_N];
  assign req_off   = req_addr[IC_M-1:2];
  // A fence in the accept cycle forces a refill even if the stale line matches.
  assign hit       = ic_rvalid && (ic_rtag == req_tag) && !fencei;
  assign beat_last = (beat_q == '1);

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign ic_index   = (state_q == S_IDLE) ? req_idx : idx_q;
  // Write is combinational so a fence landing in the WB cycle still blocks it.
  assign ic_we      = (state_q == S_WB) && !err_q && !kill_q && !fencei;
  assign ic_waddr   = idx_q;
  assign ic_wtag    = tag_q;
  assign ic_wline   = line_q;
  assign arvalid    = arvalid_q;
  assign araddr     = araddr_q;
  assign arlen      = 8'(LW - 1);
  assign arsize     = 3'b010;
  assign arburst    = 2'b01;
  assign rready     = rready_q;

  // Controller FSM with all handshake outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      tag_q        <= '0;
      off_q        <= '0;
      beat_q       <= '0;
      line_q       <= '0;
      err_q        <= 1'b0;
      kill_q       <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      rready_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            idx_q       <= req_idx;
            tag_q       <= req_tag;
            off_q       <= req_off;
            if (hit) begin
              resp_valid_q <= 1'b1;
              resp_data_q  <= rline_w[req_off];
              resp_err_q   <= 1'b0;
              state_q      <= S_RESP;
            end else begin
              arvalid_q <= 1'b1;
              araddr_q  <= req_addr & ~32'(LINE_B - 1);
              state_q   <= S_AR;
            end
          end
        end
        S_AR: begin
          if (fencei) kill_q <= 1'b1;
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= '0;
            state_q   <= S_R;
          end
        end
        S_R: begin
          if (fencei) kill_q <= 1'b1;
          if (rvalid) begin
            line_q[beat_q] <= rdata;
            beat_q         <= beat_q + BW'(1);
            // Bad response, early rlast, or wrap without rlast all poison the line.
            if ((rresp != 2'b00) || (rlast != beat_last)) err_q <= 1'b1;
            if (rlast) begin
              rready_q <= 1'b0;
              state_q  <= S_WB;
            end
          end
        end
        S_WB: begin
          resp_valid_q <= 1'b1;
          resp_data_q  <= line_q[off_q];
          resp_err_q   <= err_q;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            kill_q       <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_icache_refill.sv
// Randomised bench for the icache refill controller with a behavioural line
// store, AXI read slave and cache-content reference model.
module tb_ysyx_24080006_icache_refill;

  localparam int LW       = 4;
  localparam int FENCE_WB = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         fencei;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_data;
  logic         resp_err;
  logic [3:0]   ic_index;
  logic         ic_rvalid;
  logic [23:0]  ic_rtag;
  logic [127:0] ic_rline;
  logic         ic_we;
  logic [3:0]   ic_waddr;
  logic [23:0]  ic_wtag;
  logic [127:0] ic_wline;
  logic         arvalid;
  logic         arready;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         rvalid;
  logic         rready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;

  // Environment line store (what the DUT talks to)
  logic         st_valid [16];
  logic [23:0]  st_tag   [16];
  logic [127:0] st_line  [16];
  // Reference model of expected cache contents
  logic         m_valid  [16];
  logic [23:0]  m_tag    [16];

  ysyx_24080006_icache_refill #(.IC_N(4), .IC_M(4)) dut (
    .clock(clock), .reset(reset), .fencei(fencei),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .ic_index(ic_index), .ic_rvalid(ic_rvalid), .ic_rtag(ic_rtag), .ic_rline(ic_rline),
    .ic_we(ic_we), .ic_waddr(ic_waddr), .ic_wtag(ic_wtag), .ic_wline(ic_wline),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  always #5 clock = ~clock;

  assign ic_rvalid = st_valid[ic_index];
  assign ic_rtag   = st_tag[ic_index];
  assign ic_rline  = st_line[ic_index];

  // Line store: self-invalidates on fence, otherwise takes the DUT write.
  always @(posedge clock) begin
    if (fencei) begin
      for (int i = 0; i < 16; i++) st_valid[i] <= 1'b0;
    end else if (ic_we) begin
      st_valid[ic_waddr] <= 1'b1;
      st_tag[ic_waddr]   <= ic_wtag;
      st_line[ic_waddr]  <= ic_wline;
    end
    if (ic_we) we_cnt <= we_cnt + 1;
  end

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a[31:4] == 28'h8000001) return 32'h11 * (32'(a[3:2]) + 32'd1);
    return {a[31:2], 2'b00} ^ 32'h5A3C_96E1 ^ {a[15:2], a[31:16], 2'b10};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One fetch transaction with optional bus error, fence, short/long burst,
  // backpressure and mid-burst reset; expectations come from the model.
  task automatic fetch(input logic [31:0] a, input int err_beat, input int fence_beat,
                       input int nb, input int arw, input int rw, input int rst_at);
    logic [3:0]   idx;
    logic [23:0]  tg;
    logic [31:0]  base;
    logic [31:0]  exp_word;
    logic [127:0] exp_line;
    logic         exp_hit, exp_err, exp_we, fenced, data_ok;
    int           n, we0;
    idx      = a[7:4];
    tg       = a[31:8];
    base     = {a[31:4], 4'h0};
    exp_word = memw({a[31:2], 2'b00});
    exp_hit  = m_valid[idx] && (m_tag[idx] == tg);
    fenced   = !exp_hit && (((fence_beat >= 0) && (fence_beat < nb)) || (fence_beat == FENCE_WB));
    exp_err  = !exp_hit && ((nb != LW) || ((err_beat >= 0) && (err_beat < nb)));
    exp_we   = !exp_hit && !exp_err && !fenced;
    data_ok  = exp_hit || (nb == LW);
    for (int i = 0; i < LW; i++) exp_line[i*32 +: 32] = memw(base + 32'(4 * i));
    we0 = we_cnt;

    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("req_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = a;
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;

    if (exp_hit) begin
      check("hit_resp_valid", resp_valid, 1'b1);
      check("hit_no_ar", arvalid, 1'b0);
    end else begin
      check("ar_valid", arvalid, 1'b1);
      check("araddr", araddr, base);
      check("arlen", arlen, 8'd3);
      check("ar_size_burst", {arsize, arburst}, 5'b010_01);
      check("req_ready_busy", req_ready, 1'b0);
      repeat (arw) begin
        @(posedge clock); #1;
        check("ar_hold", {arvalid, araddr}, {1'b1, base});
      end
      arready = 1'b1;
      @(posedge clock); #1;
      arready = 1'b0;
      check("r_ready", {arvalid, rready}, 2'b01);
      for (int i = 0; i < nb; i++) begin
        if (i == rst_at) begin
          reset = 1'b1;
          #1;
          check("rst_ctl", {req_ready, resp_valid, resp_err, arvalid, rready, ic_we}, 6'b0);
          check("rst_data", {resp_data, araddr, ic_waddr, ic_wtag}, '0);
          check("rst_line", ic_wline, '0);
          @(posedge clock); #1;
          reset = 1'b0;
          return;
        end
        repeat ($urandom_range(0, 2)) begin
          @(posedge clock); #1;
        end
        rvalid = 1'b1;
        rdata  = memw(base + 32'(4 * i));
        rresp  = (i == err_beat) ? 2'b10 : 2'b00;
        rlast  = (i == nb - 1);
        fencei = (i == fence_beat);
        @(posedge clock); #1;
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        fencei = 1'b0;
      end
      if (fence_beat == FENCE_WB) fencei = 1'b1;
      #1;
      check("wb_we", ic_we, exp_we);
      if (exp_we) begin
        check("wb_waddr", ic_waddr, idx);
        check("wb_wtag", ic_wtag, tg);
        check("wb_wline", ic_wline, exp_line);
      end
      @(posedge clock); #1;
      fencei = 1'b0;
    end

    check("resp_valid", resp_valid, 1'b1);
    check("resp_err", resp_err, exp_err);
    if (data_ok) check("resp_data", resp_data, exp_word);
    check("req_ready_resp", req_ready, 1'b0);
    repeat (rw) begin
      @(posedge clock); #1;
      check("resp_hold", {req_ready, resp_valid, resp_err}, {1'b0, 1'b1, exp_err});
      if (data_ok) check("resp_hold_data", resp_data, exp_word);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    check("resp_done", resp_valid, 1'b0);
    check("we_count", 32'(we_cnt - we0), exp_we ? 32'd1 : 32'd0);

    if (fenced) for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    if (exp_we) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end
  endtask

  initial begin
    logic [31:0] a;
    int eb, fb, nb;
    for (int i = 0; i < 16; i++) begin
      st_valid[i] = 1'b0;
      st_tag[i]   = '0;
      st_line[i]  = '0;
      m_valid[i]  = 1'b0;
      m_tag[i]    = '0;
    end
    reset      = 1'b1;
    fencei     = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    resp_ready = 1'b0;
    arready    = 1'b0;
    rvalid     = 1'b0;
    rdata      = '0;
    rresp      = 2'b00;
    rlast      = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_ctl", {req_ready, resp_valid, resp_err, arvalid, rready, ic_we}, 6'b0);
    check("reset_data", {resp_data, araddr}, '0);
    reset = 1'b0;

    fetch(32'h8000_0014, -1, -1, LW, 0, 0, -1);  // cold miss
    fetch(32'h8000_001C, -1, -1, LW, 0, 0, -1);  // hit
    fetch(32'h8000_0114, -1, -1, LW, 0, 0, -1);  // tag conflict
    fetch(32'h8000_0214,  2, -1, LW, 0, 0, -1);  // bus error
    fetch(32'h8000_0210, -1, -1, LW, 0, 0, -1);  // misses again
    fetch(32'h8000_0314, -1,  1, LW, 0, 0, -1);  // fence during R
    fetch(32'h8000_0318, -1, -1, LW, 5, 3, -1);  // backpressure
    fetch(32'h8000_031C, -1, -1, LW, 0, 2, -1);  // hit with backpressure
    fetch(32'h8000_0418, -1, -1, 3,  0, 0, -1);  // early rlast
    fetch(32'h8000_0508, -1, -1, 5,  0, 0, -1);  // missing rlast
    fetch(32'h8000_0518, -1, FENCE_WB, LW, 1, 0, -1);  // fence in WB
    fetch(32'h8000_0614, -1, -1, LW, 0, 0, 2);   // reset mid-burst
    fetch(32'h8000_0614, -1, -1, LW, 0, 0, -1);
    fetch(32'h8000_0610, -1, -1, LW, 0, 0, -1);

    for (int t = 0; t < 80; t++) begin
      a  = {24'h800000 + 24'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      eb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      fb = ($urandom_range(0, 7) == 0) ?
           (($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : FENCE_WB) : -1;
      nb = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 3 : 5) : LW;
      fetch(a, eb, fb, nb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24080006_icache_refill.md
Name: ysyx_24080006_icache_refill

Overview:
- Instruction-cache controller, sitting between the IF fetch port and the AXI4 read channel.
- Performs tag lookup against the icache line store through its combinational read port.
- On a miss, issues an INCR read burst, assembles the line, and writes it into the line store through its single write port.
- Returns the requested 32-bit instruction word to IF with a valid/ready handshake.

Parameters:
- IC_N, 4, index bits; the line store holds 2^IC_N lines.
- IC_M, 4, offset bits; line = 2^IC_M bytes, LW = 2^(IC_M-2) words.
- TAG_W, 32-IC_N-IC_M, tag width.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high; all state cleared.
- fencei  in  1  instruction-fence pulse, also driven to the line store.
- req_valid  in  1  fetch request.
- req_ready  out  1  request accepted when req_valid&&req_ready.
- req_addr  in  32  fetch byte address; bits [1:0] ignored.
- resp_valid  out  1  response valid.
- resp_ready  in  1  IF accepts response.
- resp_data  out  32  instruction word.
- resp_err  out  1  bus error on the refill.
- ic_index  out  IC_N  line-store read index.
- ic_rvalid  in  1  line valid bit.
- ic_rtag  in  TAG_W  line tag.
- ic_rline  in  32*LW  line data, word 0 in LSBs.
- ic_we  out  1  line-store write enable.
- ic_waddr  out  IC_N  write index.
- ic_wtag  out  TAG_W  write tag; written valid bit is implicitly 1.
- ic_wline  out  32*LW  write data.
- arvalid  out  1  AXI AR valid.
- arready  in  1  AXI AR ready.
- araddr  out  32  line-aligned address.
- arlen  out  8  LW-1.
- arsize  out  3  constant 3'b010.
- arburst  out  2  constant 2'b01 (INCR).
- rvalid  in  1  AXI R valid.
- rready  out  1  AXI R ready.
- rdata  in  32  beat data.
- rresp  in  2  beat response.
- rlast  in  1  last beat.

Behaviour:
- States: IDLE, AR, R, WB, RESP. Reset value is IDLE; all outputs are 0; line buffer, beat counter and flags are cleared.
- ic_index is req_addr[IC_M+IC_N-1:IC_M] in IDLE, otherwise the registered index.
- IDLE:
  - req_ready=1.
  - On accept, latch the address.
  - hit = ic_rvalid && ic_rtag==tag(req_addr), with fencei low.
  - Hit: go to RESP; resp_data = the ic_rline word at addr[IC_M-1:2]; resp_valid rises the next cycle (1-cycle latency).
  - Miss, or fencei high in the accept cycle: go to AR.
- AR:
  - arvalid=1 and araddr = {tag,index,IC_M'b0}; both held stable until arready.
  - Then go to R. arvalid is never dropped before the handshake.
- R:
  - rready=1.
  - Each rvalid beat writes rdata into line-buffer word[beat] and increments the beat counter (IC_M-2 bits).
  - Any rresp!=0 sets the err flag.
  - If rlast arrives with beat!=LW-1, or beat wraps without rlast, the err flag is set.
  - On the rlast beat, go to WB.
- WB (1 cycle):
  - ic_we=1 with the latched index, tag and line, unless err or the kill flag is set.
  - resp_data is the requested word; go to RESP.
- RESP:
  - resp_valid=1; resp_data and resp_err are held stable until resp_ready.
  - Then clear err and kill, and return to IDLE.
  - Request acceptance is single-outstanding: no new request while not IDLE.
- fencei:
  - In R or AR, it sets the kill flag: the burst still completes and data is still returned, but ic_we is suppressed in WB.
  - In WB, it suppresses ic_we that cycle.
  - In IDLE or RESP, it has no local effect; the line store invalidates itself.
- The critical word is not forwarded early; the response always follows the full burst.
- Reset asserted mid-burst: the FSM returns to IDLE immediately. The interconnect must also be reset, since the outstanding burst is abandoned.

Test Plan (IC_N=4, IC_M=4, LW=4):
- Cold miss at 0x8000_0014: AR araddr=0x8000_0010, arlen=3; beats 0x11,0x22,0x33,0x44 with rlast on the 4th → one-cycle ic_we, ic_waddr=1, ic_wtag=0x800000, line {0x44,0x33,0x22,0x11}; resp_data=0x22, resp_err=0.
- Hit after refill, fetch 0x8000_001C → no arvalid; resp_valid the cycle after accept, resp_data=0x44.
- Tag conflict at 0x8000_0114 (index 1, different tag) → miss; refill overwrites line 1 with ic_wtag=0x800001.
- rresp=2'b10 on beat 2 → ic_we never asserted; resp_err=1; the next fetch to the same line misses again.
- fencei pulse during R → burst completes, resp_data correct, ic_we stays 0.
- Backpressure: arready low for 5 cycles with araddr stable; resp_ready low for 3 cycles with resp_valid and resp_data held and req_ready=0.
- Reset during R → all outputs 0 next cycle; the following request is serviced normally.
